// File: rtl/cpu_program_sequencer_if.sv
// Host/CPU-side signal bundle for the program sequencer.
// master: host load path plus the CPU done line; slave: the sequencer itself.
interface cpu_program_sequencer_if #(
   parameter int ADDR_W = 4
);
   logic              start;
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [15:0]       load_data;
   logic              done;
   logic              cpu_resetn;
   logic              run;
   logic [15:0]       din;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              halted;
   logic              error;
   logic [15:0]       instr_count;

   modport master (
      output start, load_en, load_addr, load_data, done,
      input  cpu_resetn, run, din, pc, busy, halted, error, instr_count
   );

   modport slave (
      input  start, load_en, load_addr, load_data, done,
      output cpu_resetn, run, din, pc, busy, halted, error, instr_count
   );
endinterface

// File: rtl/cpu_program_sequencer.sv
// Instruction-side sequencer for the 16-bit multicycle CPU: holds a loadable
// program memory, feeds instruction/immediate words on din while run is high,
// owns the CPU reset and follows done pulses to advance the program counter.
module cpu_program_sequencer #(
   parameter int ADDR_W = 4,
   parameter int WDOG   = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   cpu_program_sequencer_if.slave  sif
);
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int WDOG_W = $clog2(WDOG + 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG - 1);
   localparam logic [ADDR_W-1:0] PC_LAST   = ADDR_W'(DEPTH - 1);

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_HALT = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_FETCH,
      S_EXEC,
      S_STOP
   } state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   pc_reg, pc_next;
   logic [15:0]         count_reg, count_next;
   logic                halted_reg, halted_next;
   logic                error_reg, error_next;
   logic [WDOG_W-1:0]   wdog_reg, wdog_next;
   logic                cpu_resetn_reg;

   logic [15:0]         mem [DEPTH];

   logic [15:0]         cur_word;
   logic [15:0]         imm_word;
   logic [2:0]          cur_op;
   logic [ADDR_W-1:0]   pc_plus1;
   logic [ADDR_W:0]     pc_sum;
   logic                op_legal;
   logic                run_c;
   logic [15:0]         din_c;

   // Combinational read of the current word and the word after it (MVI immediate).
   assign pc_plus1 = pc_reg + ADDR_W'(1);
   assign cur_word = mem[pc_reg];
   assign imm_word = mem[pc_plus1];
   assign cur_op   = cur_word[8:6];
   assign op_legal = (cur_op == OP_MV) || (cur_op == OP_MVI) ||
                     (cur_op == OP_ADD) || (cur_op == OP_SUB);
   // One extra bit so running past the last word is visible as the carry.
   assign pc_sum   = {1'b0, pc_reg} + ((cur_op == OP_MVI) ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));

   // Program memory write port; only the host may write while the CPU is idle.
   always_ff @(posedge clk) begin
      if (sif.load_en && (state_reg == S_IDLE || state_reg == S_STOP)) begin
         mem[sif.load_addr] <= sif.load_data;
      end
   end

   // State and status registers; cpu_resetn follows the state being entered.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg      <= S_IDLE;
         pc_reg         <= '0;
         count_reg      <= '0;
         halted_reg     <= 1'b0;
         error_reg      <= 1'b0;
         wdog_reg       <= '0;
         cpu_resetn_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         count_reg      <= count_next;
         halted_reg     <= halted_next;
         error_reg      <= error_next;
         wdog_reg       <= wdog_next;
         cpu_resetn_reg <= (state_next != S_IDLE) && (state_next != S_RST);
      end
   end

   // Next-state, bookkeeping and the run/din bus drive.
   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      count_next  = count_reg;
      halted_next = halted_reg;
      error_next  = error_reg;
      wdog_next   = wdog_reg;
      run_c       = 1'b0;
      din_c       = 16'h0000;

      case (state_reg)
         S_IDLE, S_STOP: begin
            if (sif.start) begin
               pc_next     = '0;
               count_next  = '0;
               halted_next = 1'b0;
               error_next  = 1'b0;
               state_next  = S_RST;
            end
         end

         S_RST: begin
            state_next = S_FETCH;
         end

         S_FETCH: begin
            if (cur_op == OP_HALT) begin
               halted_next = 1'b1;
               state_next  = S_STOP;
            end else if (!op_legal || (cur_op == OP_MVI && pc_reg == PC_LAST)) begin
               // Illegal opcode, or an MVI whose immediate would lie past the end.
               halted_next = 1'b1;
               error_next  = 1'b1;
               state_next  = S_STOP;
            end else begin
               run_c      = 1'b1;
               din_c      = cur_word;
               wdog_next  = '0;
               state_next = S_EXEC;
            end
         end

         S_EXEC: begin
            run_c = 1'b1;
            // The CPU samples the MVI immediate during its step 1.
            din_c = (cur_op == OP_MVI) ? imm_word : cur_word;
            if (sif.done) begin
               pc_next    = pc_sum[ADDR_W-1:0];
               count_next = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;
               if (pc_sum[ADDR_W]) begin
                  halted_next = 1'b1;
                  state_next  = S_STOP;
               end else begin
                  state_next = S_FETCH;
               end
            end else if (wdog_reg == WDOG_LAST) begin
               halted_next = 1'b1;
               error_next  = 1'b1;
               state_next  = S_STOP;
            end else begin
               wdog_next = wdog_reg + WDOG_W'(1);
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign sif.cpu_resetn  = cpu_resetn_reg;
   assign sif.run         = run_c;
   assign sif.din         = din_c;
   assign sif.pc          = pc_reg;
   assign sif.busy        = (state_reg == S_RST) || (state_reg == S_FETCH) || (state_reg == S_EXEC);
   assign sif.halted      = halted_reg;
   assign sif.error       = error_reg;
   assign sif.instr_count = count_reg;
endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Directed bench for cpu_program_sequencer with a small behavioural CPU.
module tb_cpu_program_sequencer;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic cpu_disconnect = 1'b0;

   always #5 clk = ~clk;

   cpu_program_sequencer_if #(.ADDR_W(4)) sif_a ();
   cpu_program_sequencer_if #(.ADDR_W(2)) sif_b ();

   cpu_program_sequencer #(.ADDR_W(4), .WDOG(4)) dut_a (.clk(clk), .resetn(resetn), .sif(sif_a));
   cpu_program_sequencer #(.ADDR_W(2), .WDOG(4)) dut_b (.clk(clk), .resetn(resetn), .sif(sif_b));

   // Behavioural multicycle CPU: MV/MVI finish at step 1, ADD/SUB at step 3.
   logic [15:0] cpu_r [8];
   logic [15:0] cpu_ir, cpu_a, cpu_g;
   logic [1:0]  cpu_step;
   logic        a_cpu_resetn;
   logic        model_done;
   logic [2:0]  ir_op, ir_rx, ir_ry;
   assign a_cpu_resetn = sif_a.cpu_resetn;
   assign ir_op = cpu_ir[8:6];
   assign ir_rx = cpu_ir[5:3];
   assign ir_ry = cpu_ir[2:0];
   assign model_done = (cpu_step == 2'd1 && (ir_op == 3'b000 || ir_op == 3'b001)) || (cpu_step == 2'd3);
   assign sif_a.done = cpu_disconnect ? 1'b0 : model_done;

   always @(posedge clk or negedge a_cpu_resetn) begin
      if (!a_cpu_resetn) begin
         cpu_step <= 2'd0;
         cpu_ir   <= 16'h0;
         cpu_a    <= 16'h0;
         cpu_g    <= 16'h0;
         for (int i = 0; i < 8; i++) cpu_r[i] <= 16'h0;
      end else begin
         case (cpu_step)
            2'd0: if (sif_a.run) begin cpu_ir <= sif_a.din; cpu_step <= 2'd1; end
            2'd1: begin
               if (ir_op == 3'b000) begin cpu_r[ir_rx] <= cpu_r[ir_ry]; cpu_step <= 2'd0; end
               else if (ir_op == 3'b001) begin cpu_r[ir_rx] <= sif_a.din; cpu_step <= 2'd0; end
               else begin cpu_a <= cpu_r[ir_rx]; cpu_step <= 2'd2; end
            end
            2'd2: begin
               cpu_g <= (ir_op == 3'b010) ? cpu_a + cpu_r[ir_ry] : cpu_a - cpu_r[ir_ry];
               cpu_step <= 2'd3;
            end
            default: begin cpu_r[ir_rx] <= cpu_g; cpu_step <= 2'd0; end
         endcase
      end
   end

   // Minimal CPU for the small instance: programs there only contain MV.
   logic b_step;
   logic b_cpu_resetn;
   assign b_cpu_resetn = sif_b.cpu_resetn;
   assign sif_b.done = b_step;
   always @(posedge clk or negedge b_cpu_resetn) begin
      if (!b_cpu_resetn) b_step <= 1'b0;
      else if (b_step) b_step <= 1'b0;
      else if (sif_b.run) b_step <= 1'b1;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_a(input logic [3:0] a, input logic [15:0] d);
      sif_a.load_en = 1'b1; sif_a.load_addr = a; sif_a.load_data = d;
      tick();
      sif_a.load_en = 1'b0;
   endtask

   task automatic load_b(input logic [1:0] a, input logic [15:0] d);
      sif_b.load_en = 1'b1; sif_b.load_addr = a; sif_b.load_data = d;
      tick();
      sif_b.load_en = 1'b0;
   endtask

   task automatic start_a();
      sif_a.start = 1'b1; tick(); sif_a.start = 1'b0;
   endtask

   task automatic start_b();
      sif_b.start = 1'b1; tick(); sif_b.start = 1'b0;
   endtask

   task automatic wait_stop_a(input string tag);
      int n = 0;
      while (sif_a.busy && n < 200) begin tick(); n++; end
      check(tag, 16'(sif_a.busy), 16'h0);
   endtask

   task automatic wait_stop_b(input string tag);
      int n = 0;
      while (sif_b.busy && n < 200) begin tick(); n++; end
      check(tag, 16'(sif_b.busy), 16'h0);
   endtask

   logic [15:0] exp_din [8] = '{16'h0040, 16'h0005, 16'h0048, 16'h0003,
                                16'h0081, 16'h0081, 16'h0081, 16'h0081};
   logic run_seen;
   int   n;

   initial begin
      sif_a.start = 0; sif_a.load_en = 0; sif_a.load_addr = 0; sif_a.load_data = 0;
      sif_b.start = 0; sif_b.load_en = 0; sif_b.load_addr = 0; sif_b.load_data = 0;
      tick(); tick();

      // Reset state
      check("rst_run", 16'(sif_a.run), 16'h0);
      check("rst_cpu_resetn", 16'(sif_a.cpu_resetn), 16'h0);
      check("rst_busy", 16'(sif_a.busy), 16'h0);
      check("rst_flags", {14'h0, sif_a.halted, sif_a.error}, 16'h0);
      check("rst_count", sif_a.instr_count, 16'h0);
      check("rst_din", sif_a.din, 16'h0);
      check("rst_pc", 16'(sif_a.pc), 16'h0);
      resetn = 1'b1;
      tick();
      $display("step: reset state checked");

      // MVI R0,5 ; MVI R1,3 ; ADD R0,R1 ; HALT
      load_a(0, 16'h0040); load_a(1, 16'h0005); load_a(2, 16'h0048);
      load_a(3, 16'h0003); load_a(4, 16'h0081); load_a(5, 16'h01C0);
      start_a();
      check("rst_phase_cpu_resetn", 16'(sif_a.cpu_resetn), 16'h0);
      check("rst_phase_run", 16'(sif_a.run), 16'h0);
      check("rst_phase_busy", 16'(sif_a.busy), 16'h1);
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("prog1_run%0d", i), 16'(sif_a.run), 16'h1);
         check($sformatf("prog1_din%0d", i), sif_a.din, exp_din[i]);
      end
      check("prog1_cpu_resetn_hi", 16'(sif_a.cpu_resetn), 16'h1);
      tick();
      check("prog1_run_drop", 16'(sif_a.run), 16'h0);
      wait_stop_a("prog1_timeout");
      check("prog1_pc", 16'(sif_a.pc), 16'h5);
      check("prog1_halted", 16'(sif_a.halted), 16'h1);
      check("prog1_error", 16'(sif_a.error), 16'h0);
      check("prog1_count", sif_a.instr_count, 16'h3);
      check("prog1_r0", cpu_r[0], 16'h0008);
      $display("step: MVI/MVI/ADD program done count=%0d", sif_a.instr_count);

      // SUB wrap: FFFF - 1
      load_a(1, 16'hFFFF); load_a(3, 16'h0001); load_a(4, 16'h00C1);
      start_a();
      wait_stop_a("sub_timeout");
      check("sub_r0", cpu_r[0], 16'hFFFE);
      check("sub_count", sif_a.instr_count, 16'h3);
      check("sub_error", 16'(sif_a.error), 16'h0);
      $display("step: SUB wrap program done r0=%h", cpu_r[0]);

      // load_en and start together: FETCH must see the new HALT at address 0
      sif_a.load_en = 1'b1; sif_a.load_addr = 0; sif_a.load_data = 16'h01C0; sif_a.start = 1'b1;
      tick();
      sif_a.load_en = 1'b0; sif_a.start = 1'b0;
      wait_stop_a("ldstart_timeout");
      check("ldstart_count", sif_a.instr_count, 16'h0);
      check("ldstart_halted", 16'(sif_a.halted), 16'h1);
      check("ldstart_error", 16'(sif_a.error), 16'h0);
      $display("step: load+start same cycle done");

      // Illegal opcode
      load_a(0, 16'h0100);
      start_a();
      run_seen = 1'b0;
      n = 0;
      while (sif_a.busy && n < 50) begin run_seen |= sif_a.run; tick(); n++; end
      check("illegal_timeout", 16'(sif_a.busy), 16'h0);
      check("illegal_run", 16'(run_seen), 16'h0);
      check("illegal_halted", 16'(sif_a.halted), 16'h1);
      check("illegal_error", 16'(sif_a.error), 16'h1);
      check("illegal_pc", 16'(sif_a.pc), 16'h0);
      $display("step: illegal opcode done");

      // Watchdog with done held low
      load_a(0, 16'h0040); load_a(1, 16'h0005); load_a(2, 16'h01C0);
      cpu_disconnect = 1'b1;
      start_a();
      tick();
      check("wdog_fetch_run", 16'(sif_a.run), 16'h1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("wdog_exec_run%0d", i), 16'(sif_a.run), 16'h1);
         check($sformatf("wdog_exec_err%0d", i), 16'(sif_a.error), 16'h0);
      end
      tick();
      check("wdog_run_drop", 16'(sif_a.run), 16'h0);
      check("wdog_error", 16'(sif_a.error), 16'h1);
      check("wdog_halted", 16'(sif_a.halted), 16'h1);
      cpu_disconnect = 1'b0;
      $display("step: watchdog done");

      // load_en and start while busy are ignored
      start_a();
      tick();
      sif_a.load_en = 1'b1; sif_a.load_addr = 2; sif_a.load_data = 16'h0081; sif_a.start = 1'b1;
      tick();
      sif_a.load_en = 1'b0; sif_a.start = 1'b0;
      wait_stop_a("busyload_timeout");
      check("busyload_count", sif_a.instr_count, 16'h1);
      check("busyload_pc", 16'(sif_a.pc), 16'h2);
      check("busyload_error", 16'(sif_a.error), 16'h0);
      check("busyload_r0", cpu_r[0], 16'h0005);
      $display("step: load/start while busy done");

      // Asynchronous reset in the middle of an ADD
      load_a(0, 16'h0081); load_a(1, 16'h01C0);
      start_a();
      tick(); tick();
      check("midadd_run_before", 16'(sif_a.run), 16'h1);
      #2 resetn = 1'b0;
      #1;
      check("midadd_run", 16'(sif_a.run), 16'h0);
      check("midadd_cpu_resetn", 16'(sif_a.cpu_resetn), 16'h0);
      check("midadd_busy", 16'(sif_a.busy), 16'h0);
      #2 resetn = 1'b1;
      tick();
      check("midadd_idle", 16'(sif_a.busy), 16'h0);
      $display("step: mid-ADD reset done");

      // End of memory on the ADDR_W=2 instance
      load_b(0, 16'h0000); load_b(1, 16'h0000); load_b(2, 16'h0000); load_b(3, 16'h0040);
      start_b();
      wait_stop_b("eom_mvi_timeout");
      check("eom_mvi_error", 16'(sif_b.error), 16'h1);
      check("eom_mvi_halted", 16'(sif_b.halted), 16'h1);
      check("eom_mvi_count", sif_b.instr_count, 16'h3);
      load_b(3, 16'h0000);
      start_b();
      wait_stop_b("eom_mv_timeout");
      check("eom_mv_error", 16'(sif_b.error), 16'h0);
      check("eom_mv_halted", 16'(sif_b.halted), 16'h1);
      check("eom_mv_count", sif_b.instr_count, 16'h4);
      $display("step: end-of-memory done");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cpu_program_sequencer.md
Name: cpu_program_sequencer

Overview:
- Drives the instruction side of the 16-bit multicycle CPU. It holds a small loadable program memory, presents instruction and immediate words on the CPU `din` bus, and holds `run` high while a program executes.
- It owns the CPU reset, so the CPU step counter is at step 0 when each program starts. It then follows the CPU's `done` pulses to advance its program counter.
- It stops on a HALT word, at end of memory, or on a protocol error. It sits between the testbench or host load path and the `cpu` top.

Parameters:
- ADDR_W, 4, program memory address width; DEPTH = 2**ADDR_W words of 16 bits.
- WDOG, 4, maximum EXEC cycles without `done` before an error is flagged.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that starts the program from address 0.
- load_en  in  1  program memory write strobe.
- load_addr  in  ADDR_W  write address.
- load_data  in  16  write data.
- done  in  1  CPU done, combinational from the CPU and sampled at posedge.
- cpu_resetn  out  1  registered active-low reset to the CPU.
- run  out  1  CPU run.
- din  out  16  word presented to the CPU bus.
- pc  out  ADDR_W  address of the current instruction.
- busy  out  1  high in RST, FETCH and EXEC.
- halted  out  1  sticky; set in STOP.
- error  out  1  sticky; protocol or program fault.
- instr_count  out  16  number of completed instructions; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; pc = 0; run = 0; cpu_resetn = 0; busy = 0; halted = 0; error = 0; instr_count = 0; din = 0. Memory contents are not reset.
- Instruction word layout: opcode [8:6], rx [5:3], ry [2:0]. Opcodes:
  - 000 MV, 001 MVI, 010 ADD, 011 SUB are legal.
  - 111 is HALT and is never sent to the CPU.
  - 100–110 are illegal.
- Length: MVI is 2 words (instruction, then immediate); all others are 1 word.
- Memory: synchronous write when load_en = 1 in IDLE or STOP; load_en is ignored while busy. Read is combinational.
- IDLE: run = 0, cpu_resetn = 0. On start: clear pc, instr_count, halted and error, then go to RST.
- RST: one cycle with cpu_resetn = 0, so the CPU registers and step counter clear. Next state is FETCH.
  - cpu_resetn is a registered output: 0 in IDLE and RST, 1 in all other states.
- FETCH (CPU is at step 0): decode mem[pc].
  - HALT: run = 0, set halted, go to STOP.
  - Illegal opcode: run = 0, set halted and error, go to STOP.
  - Otherwise: run = 1, din = mem[pc], go to EXEC with the watchdog cleared.
- EXEC: run = 1. din = mem[pc+1] when the opcode is MVI (the CPU samples the immediate at step 1), otherwise din = mem[pc].
  - done = 1 at posedge: pc <= pc + length; instr_count increments (saturating). Go to FETCH, or go to STOP with halted set if pc + length ≥ DEPTH.
  - done = 0: the watchdog increments. At WDOG, set error and halted and go to STOP.
- Latency: MV and MVI take 2 cycles (FETCH, EXEC); ADD and SUB take 4 cycles (FETCH plus 3 EXEC cycles).
- MVI at address DEPTH-1 has no immediate word: detected in FETCH, run stays 0, error and halted are set, go to STOP.
- STOP: run = 0. cpu_resetn stays 1 so the CPU registers remain observable. On start, go to RST with flags cleared.
- start while busy is ignored.
- load_en and start in the same cycle in IDLE: the write completes, and FETCH reads the updated memory.
- run and din are combinational from state and memory. din = 0 whenever run = 0.

Test Plan:
- Load program [0:040, 1:0005, 2:048, 3:0003, 4:081, 5:1C0], then pulse start.
  - Required: RST for 1 cycle.
  - run is high for 8 cycles: din = 040, 0005, 048, 0003, then 081 held for 4 cycles.
  - Final: pc = 5, halted = 1, error = 0, instr_count = 3, CPU R0 = 0x0008.
- SUB wrap: load [040, FFFF(imm) → R0, 048, 0001, 0C1 SUB R0,R1, 1C0]. Required: CPU R0 = 0xFFFE, instr_count = 3.
- Illegal opcode: load [100] at address 0, then start. Required: run never asserts; halted = 1, error = 1, pc = 0.
- End of memory with ADDR_W = 2: program [000, 000, 000, 040].
  - Required: MVI at address 3 gives error = 1, instr_count = 3.
  - Repeat with word 3 = 000: halted = 1, error = 0, instr_count = 4.
- Force done low during EXEC (disconnect the CPU). Required: error = 1 after WDOG = 4 EXEC cycles; run drops the next cycle.
- Assert resetn low mid-ADD: run and cpu_resetn go to 0 immediately, state is IDLE. Then load_en during RUN: memory is unchanged.
